// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state RAM responder for an active-low strobe / busy handshake.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int WORDS       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  mem_rd_i,
   input  logic                  mem_wr_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  mem_busy_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                  misalign_o
`endif
);

   localparam int AW = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q;
   logic [AW-1:0]           cap_addr_q;
   logic [DATA_WIDTH-1:0]   cap_data_q;
   logic                    cap_wr_q;
   logic [DATA_WIDTH-1:0]   mem [WORDS] = '{default: '0};

   logic                    req;
   logic                    req_wr;
   logic [AW-1:0]           word_addr;
   logic                    req_match;
   logic                    start;
   logic                    finish;
   logic                    suppress;
   logic                    unused_addr;

   assign req         = !mem_wr_i || !mem_rd_i;
   assign req_wr      = !mem_wr_i;
   assign word_addr   = addr_i[AW+1:2];
   assign req_match   = (word_addr == cap_addr_q) && (req_wr == cap_wr_q);
   assign unused_addr = ^{addr_i[DATA_WIDTH-1:AW+2], addr_i[1:0]};

   // Busy must react in the same cycle the request appears, so it stays combinational.
   always_comb begin
      state_d    = state_q;
      mem_busy_o = 1'b0;
      start      = 1'b0;
      finish     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               mem_busy_o = 1'b1;
               start      = 1'b1;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            mem_busy_o = 1'b1;
            if (cnt_q == 4'd0) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!req) begin
               state_d = IDLE;
            end else if (!req_match) begin
               mem_busy_o = 1'b1;
               start      = 1'b1;
               state_d    = ACCESS;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         cap_addr_q <= '0;
         cap_data_q <= '0;
         cap_wr_q   <= 1'b0;
         rd_data_o  <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            cap_addr_q <= word_addr;
            cap_data_q <= wr_data_i;
            cap_wr_q   <= req_wr;
            cnt_q      <= 4'(WAIT_STATES);
         end else if (state_q == ACCESS && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (finish && !cap_wr_q) begin
            rd_data_o <= suppress ? '0 : mem[cap_addr_q];
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic cap_mis_q;

   assign suppress = cap_mis_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cap_mis_q  <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         if (start) begin
            cap_mis_q <= (addr_i[1:0] != 2'b00);
         end
         // Set on completing a misaligned access, held only while Done persists.
         misalign_o <= (state_d == DONE) && (finish ? cap_mis_q : misalign_o);
      end
   end
`else
   assign suppress = 1'b0;
`endif

   // finish is only raised in Access, which reset leaves at once, aborting any in-flight write.
   always_ff @(posedge clk_i) begin
      if (finish && cap_wr_q && !suppress) begin
         mem[cap_addr_q] <= cap_data_q;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder (WAIT_STATES 2 and 0).
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        rd, wr, rd0, wr0;
   logic [31:0] addr, wdata, rdata, addr0, wdata0, rdata0;
   logic        busy, busy0;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign;
   logic        misalign0;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [int];
   logic [31:0] model0 [int];

   always #5 clk = ~clk;

   mem_responder #(.DATA_WIDTH(32), .WORDS(1024), .WAIT_STATES(2)) dut (
      .clk_i(clk), .reset_i(reset_i), .mem_rd_i(rd), .mem_wr_i(wr),
      .addr_i(addr), .wr_data_i(wdata), .rd_data_o(rdata), .mem_busy_o(busy)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign_o(misalign)
`endif
   );

   mem_responder #(.DATA_WIDTH(32), .WORDS(16), .WAIT_STATES(0)) dut0 (
      .clk_i(clk), .reset_i(reset_i), .mem_rd_i(rd0), .mem_wr_i(wr0),
      .addr_i(addr0), .wr_data_i(wdata0), .rd_data_o(rdata0), .mem_busy_o(busy0)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign_o(misalign0)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input bit sel, input logic [31:0] a);
      return sel ? int'(a[5:2]) : int'(a[11:2]);
   endfunction

   function automatic logic [31:0] model_read(input bit sel, input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      if (sel) begin
         if (model0.exists(widx(1'b1, a))) v = model0[widx(1'b1, a)];
      end else begin
         if (model.exists(widx(1'b0, a))) v = model[widx(1'b0, a)];
      end
`ifdef MEM_MISALIGN_TRAP_EN
      if (a[1:0] != 2'b00) v = 32'h0;
`endif
      return v;
   endfunction

   // Call just after a rising edge; returns at the falling edge of the first non-busy cycle.
   task automatic access(input bit sel, input bit do_wr, input bit do_rd,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_busy, input string tag);
      int          n;
      bit          done;
      logic        b;
      logic [31:0] rv;
      if (sel) begin
         wr0 = !do_wr; rd0 = !do_rd; addr0 = a; wdata0 = d;
      end else begin
         wr = !do_wr; rd = !do_rd; addr = a; wdata = d;
      end
      if (do_wr) begin
`ifdef MEM_MISALIGN_TRAP_EN
         if (a[1:0] == 2'b00) begin
`else
         begin
`endif
            if (sel) model0[widx(1'b1, a)] = d;
            else     model[widx(1'b0, a)]  = d;
         end
      end else begin
         exp_q.push_back(model_read(sel, a));
      end
      n = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         b = sel ? busy0 : busy;
         if (b) begin
            n++;
            @(posedge clk);
            #1;
         end else begin
            done = 1;
         end
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
      if (!do_wr) begin
         rv = sel ? rdata0 : rdata;
         check({tag, "_rdata"}, rv, exp_q.pop_front());
      end
   endtask

   task automatic release_bus(input bit sel);
      if (sel) begin wr0 = 1'b1; rd0 = 1'b1; end
      else     begin wr  = 1'b1; rd  = 1'b1; end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_i = 1'b0;
      wr = 1'b1; rd = 1'b1; addr = '0; wdata = '0;
      wr0 = 1'b1; rd0 = 1'b1; addr0 = '0; wdata0 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_rdata0", rdata0, 32'h0);
      reset_i = 1'b1;
      @(posedge clk);
      #1;

      access(0, 1, 0, 32'h10, 32'hDEADBEEF, 4, "wr_10");
      release_bus(0);
      access(0, 1, 0, 32'h14, 32'hCAFEF00D, 4, "wr_14");
      release_bus(0);
      access(0, 0, 1, 32'h10, 32'h0, 4, "rd_10");

      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_busy", 32'(busy), 32'd0);
         check("hold_rdata", rdata, 32'hDEADBEEF);
      end
      access(0, 0, 1, 32'h14, 32'h0, 4, "rd_14_from_done");
      release_bus(0);

      access(0, 1, 1, 32'h20, 32'h5, 4, "both_20");
      check("both_rdata_held", rdata, 32'hCAFEF00D);
      release_bus(0);
      access(0, 0, 1, 32'h20, 32'h0, 4, "rd_20");
      release_bus(0);

      access(0, 1, 0, 32'h30, 32'h1234, 4, "wr_30");
      release_bus(0);
      wr = 1'b0; rd = 1'b1; addr = 32'h30; wdata = 32'hFFFF;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      wr = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdata", rdata, 32'h0);
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      access(0, 0, 1, 32'h30, 32'h0, 4, "rd_30_after_abort");
      release_bus(0);

      access(1, 1, 0, 32'h10, 32'hA5A5, 2, "ws0_wr_10");
      release_bus(1);
      access(1, 0, 1, 32'h10, 32'h0, 2, "ws0_rd_10");
      release_bus(1);
      access(1, 0, 1, 32'h50, 32'h0, 2, "ws0_rd_wrap");
      check("ws0_wrap_value", rdata0, 32'hA5A5);
      release_bus(1);

      access(0, 1, 0, 32'h40, 32'h99, 4, "wr_40");
      release_bus(0);
      access(0, 1, 0, 32'h41, 32'h77, 4, "wr_41");
`ifdef MEM_MISALIGN_TRAP_EN
      check("misalign_in_done", 32'(misalign), 32'd1);
`endif
      release_bus(0);
`ifdef MEM_MISALIGN_TRAP_EN
      check("misalign_cleared", 32'(misalign), 32'd0);
`endif
      access(0, 0, 1, 32'h40, 32'h0, 4, "rd_40");
      release_bus(0);
      access(0, 0, 1, 32'h41, 32'h0, 4, "rd_41");
      release_bus(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
